vga_capture: RTL

Receive-side counterpart of the bitmap-to-VGA display path. Consumes a 640x480 VGA stream (4-bit RGB, active-low hsync/vsync) synchronous to `clk_vga` and recovers frame timing from the sync edges. It decimates 2x2 to 320x240 and thresholds each channel to 1 bit. Output is a stream of `x`/`y`/`color`/`wr_en` bitmap writes, so a captured frame can be stored in the same 320x240 3-bit format the display consumes. It is used for display loopback checking and for frame grabbing.

---
 rtl/vga_capture_pkg.sv | 37 +++
 rtl/vga_sync_edge.sv | 28 ++
 rtl/vga_capture.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vga_capture_pkg.sv
// Shared timing constants, state encoding and counter widths
// for the VGA capture path.
package vga_capture_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int H_BACK_DEF   = 44;
  localparam int V_BACK_DEF   = 28;
  localparam int THRESH_DEF   = 8;
  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;

  localparam int HPIX_W = $clog2(H_ACTIVE_DEF);
  localparam int LINE_W = $clog2(V_ACTIVE_DEF);
  localparam int HB_W   = $clog2(H_BACK_DEF);
  localparam int VB_W   = $clog2(V_BACK_DEF);
  localparam int X_W    = HPIX_W - 1;
  localparam int Y_W    = LINE_W - 1;

  typedef enum logic [2:0] {
    WAIT_VSYNC,
    VBACK,
    HBACK,
    PIX,
    HWAIT
  } cap_state_t;

  function automatic logic [2:0] thresh3(
    input logic [3:0] r,
    input logic [3:0] g,
    input logic [3:0] b,
    input logic [3:0] t
  );
    return {r >= t, g >= t, b >= t};
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input and flags its rising/falling edges
// against the previous registered sample.
module vga_sync_edge (
  input  logic clk_vga,
  input  logic reset,
  input  logic sync_in,
  output logic rise,
  output logic fall
);

  logic cur;
  logic prev;

  // History idles high so reset never produces a phantom edge.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      cur  <= sync_in;
      prev <= cur;
    end
  end

  assign rise = cur & ~prev;
  assign fall = ~cur & prev;

endmodule

// File: rtl/vga_capture.sv
// Recovers VGA frame timing from sync edges, decimates 2x2 and
// thresholds to a 320x240 3-bit bitmap write stream.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int THRESH   = THRESH_DEF
) (
  input  logic           clk_vga,
  input  logic           reset,
  input  logic [3:0]     vga_r,
  input  logic [3:0]     vga_g,
  input  logic [3:0]     vga_b,
  input  logic           vga_hsync,
  input  logic           vga_vsync,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     color,
  output logic           wr_en,
  output logic           frame_done,
  output logic           locked,
  output logic           sync_err
);

  logic [3:0] r_q, g_q, b_q;
  logic       hs_rise, hs_fall;
  logic       vs_rise, vs_fall;

  cap_state_t        state, state_n;
  logic [HPIX_W-1:0] hpix, hpix_n;
  logic [LINE_W-1:0] line, line_n;
  logic [HB_W-1:0]   hb_cnt, hb_n;
  logic [VB_W-1:0]   vb_cnt, vb_n;
  logic              abort;
  logic              write;
  logic              last_px;

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= vga_r;
      g_q <= vga_g;
      b_q <= vga_b;
    end
  end

  vga_sync_edge u_hs (
    .clk_vga (clk_vga),
    .reset   (reset),
    .sync_in (vga_hsync),
    .rise    (hs_rise),
    .fall    (hs_fall)
  );

  vga_sync_edge u_vs (
    .clk_vga (clk_vga),
    .reset   (reset),
    .sync_in (vga_vsync),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      state  <= WAIT_VSYNC;
      hpix   <= '0;
      line   <= '0;
      hb_cnt <= '0;
      vb_cnt <= '0;
    end else begin
      state  <= state_n;
      hpix   <= hpix_n;
      line   <= line_n;
      hb_cnt <= hb_n;
      vb_cnt <= vb_n;
    end
  end

  // hb_cnt counts cycles since the hsync rise, so the line
  // edge itself loads 1 and PIX starts H_BACK cycles after it.
  always_comb begin
    state_n = state;
    hpix_n  = hpix;
    line_n  = line;
    hb_n    = hb_cnt;
    vb_n    = vb_cnt;
    abort   = 1'b0;
    unique case (state)
      WAIT_VSYNC: begin
        if (vs_rise) begin
          state_n = VBACK;
          vb_n    = '0;
        end
      end
      VBACK: begin
        if (vs_fall) begin
          abort = 1'b1;
        end else if (hs_rise) begin
          if (vb_cnt == VB_W'(V_BACK)) begin
            state_n = HBACK;
            line_n  = '0;
            hb_n    = HB_W'(1);
          end else begin
            vb_n = vb_cnt + 1'b1;
          end
        end
      end
      HBACK: begin
        if (vs_fall || hs_fall) begin
          abort = 1'b1;
        end else if (hb_cnt == HB_W'(H_BACK - 1)) begin
          state_n = PIX;
          hpix_n  = '0;
        end else begin
          hb_n = hb_cnt + 1'b1;
        end
      end
      PIX: begin
        if (vs_fall || hs_fall) begin
          abort = 1'b1;
        end else if (hpix == HPIX_W'(H_ACTIVE - 1)) begin
          state_n = HWAIT;
        end else begin
          hpix_n = hpix + 1'b1;
        end
      end
      HWAIT: begin
        if (vs_fall) begin
          abort = 1'b1;
        end else if (hs_rise) begin
          if (line == LINE_W'(V_ACTIVE - 1)) begin
            state_n = WAIT_VSYNC;
          end else begin
            state_n = HBACK;
            line_n  = line + 1'b1;
            hb_n    = HB_W'(1);
          end
        end
      end
      default: state_n = WAIT_VSYNC;
    endcase
    if (abort) state_n = WAIT_VSYNC;
  end

  assign write   = (state == PIX) && !hpix[0] && !line[0] && !abort;
  assign last_px = (hpix == HPIX_W'(H_ACTIVE - 2)) &&
                   (line == LINE_W'(V_ACTIVE - 2));

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      color      <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      wr_en      <= write;
      frame_done <= write && last_px;
      locked     <= (state != WAIT_VSYNC);
      sync_err   <= abort;
      if (write) begin
        x     <= hpix[HPIX_W-1:1];
        y     <= line[LINE_W-1:1];
        color <= thresh3(r_q, g_q, b_q, 4'(THRESH));
      end
    end
  end

endmodule
